// File: rtl/reg_arb_pkg.sv
// reg_arb_pkg: shared types, default sizes and width helpers for reg_wr_arbiter
package reg_arb_pkg;

    typedef enum logic [1:0] {IDLE, GRANT, BURST} state_t;

    localparam int ARB_N         = 4;
    localparam int ARB_W         = 8;
    localparam int ARB_MAX_BURST = 4;

    function automatic int id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int cnt_w(input int max_burst);
        return $clog2(max_burst + 1);
    endfunction

    localparam int ARB_ID_W  = id_w(ARB_N);
    localparam int ARB_CNT_W = cnt_w(ARB_MAX_BURST);

endpackage

// File: rtl/rr_prio_enc.sv
// rr_prio_enc: rotating priority encoder, first set bit of req searching upward from ptr+1 with wrap
module rr_prio_enc
    import reg_arb_pkg::*;
#(
    parameter int N  = ARB_N,
    parameter int IW = id_w(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic          vld,
    output logic [IW-1:0] idx
);

    logic [IW-1:0] j;

    // scan from the farthest offset down so the closest candidate after ptr is written last
    always_comb begin
        vld = 1'b0;
        idx = '0;
        j   = '0;
        for (int k = N; k >= 1; k--) begin
            j = IW'((int'(ptr) + k) % N);
            if (req[j]) begin
                vld = 1'b1;
                idx = j;
            end
        end
    end

endmodule

// File: rtl/reg_wr_arbiter.sv
// reg_wr_arbiter: round-robin write arbiter feeding one shared register; REG_ARB_BURST_EN enables locked bursts
module reg_wr_arbiter
    import reg_arb_pkg::*;
#(
    parameter int N         = ARB_N,
    parameter int W         = ARB_W,
    parameter int MAX_BURST = ARB_MAX_BURST
) (
    input  logic                 clk,
    input  logic                 clr_n,
    input  logic [N-1:0]         req,
    input  logic [N*W-1:0]       wdata,
    input  logic [N-1:0]         lock,
    output logic [N-1:0]         gnt,
    output logic [id_w(N)-1:0]   gnt_id,
    output logic                 ld,
    output logic [W-1:0]         data_out,
    output logic                 busy
);

    localparam int IW = id_w(N);

    if (N < 2 || N > 16) begin : g_bad_n
        $error("reg_wr_arbiter: N must be 2..16");
    end
    if (MAX_BURST < 1 || MAX_BURST > 15) begin : g_bad_burst
        $error("reg_wr_arbiter: MAX_BURST must be 1..15");
    end

    state_t        state, state_n;
    logic [IW-1:0] ptr, ptr_n, win, id_n;
    logic [N-1:0]  eff_req, gnt_n;
    logic          vld, ld_n;
    logic [W-1:0]  dout_n;
    logic [W-1:0]  words [N];

    for (genvar g = 0; g < N; g++) begin : g_words
        assign words[g] = wdata[g*W +: W];
    end

    // last cycle's winner sits out one round so a lone requester cannot hog the register
    assign eff_req = req & ~gnt;
    assign busy    = (state != IDLE);

    rr_prio_enc #(.N(N), .IW(IW)) u_enc (
        .req (eff_req),
        .ptr (ptr),
        .vld (vld),
        .idx (win)
    );

`ifdef REG_ARB_BURST_EN
    localparam int CW = cnt_w(MAX_BURST);
    logic [CW-1:0] cnt, cnt_n;
    logic          hold;

    assign hold = (state == BURST) && req[gnt_id] && lock[gnt_id] && (int'(cnt) < MAX_BURST);

    // burst length counter, cleared whenever the burst owner lets go
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) cnt <= '0;
        else        cnt <= cnt_n;
    end
`else
    logic unused_lock;
    assign unused_lock = ^lock;
`endif

    // next grant: normal rotation, overridden by an active burst owner when bursts are built in
    always_comb begin
        state_n = vld ? GRANT : IDLE;
        gnt_n   = '0;
        gnt_n[win] = vld;
        id_n    = vld ? win : gnt_id;
        ld_n    = vld;
        dout_n  = vld ? words[win] : data_out;
        ptr_n   = vld ? win : ptr;
`ifdef REG_ARB_BURST_EN
        cnt_n   = '0;
        if (hold) begin
            state_n = BURST;
            gnt_n   = gnt;
            id_n    = gnt_id;
            ld_n    = 1'b1;
            dout_n  = words[gnt_id];
            ptr_n   = gnt_id;
            cnt_n   = cnt + 1'b1;
        end else if (vld && lock[win]) begin
            state_n = BURST;
            cnt_n   = CW'(1);
        end
`endif
    end

    // registered outputs and arbitration state; ptr resets to N-1 so requester 0 leads
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state    <= IDLE;
            ptr      <= IW'(N-1);
            gnt      <= '0;
            gnt_id   <= '0;
            ld       <= 1'b0;
            data_out <= '0;
        end else begin
            state    <= state_n;
            ptr      <= ptr_n;
            gnt      <= gnt_n;
            gnt_id   <= id_n;
            ld       <= ld_n;
            data_out <= dout_n;
        end
    end

endmodule
